rv32i_encoder: RTL and testbench

- Streaming RV32I instruction encoder: the inverse of the instruction decoder.
- Accepts instruction fields (format, opcode, register indices, funct3/funct7, 32-bit immediate) over a valid/ready handshake.
- Range-checks the immediate, packs it into a 32-bit instruction word and presents it with its target byte address on a registered valid/ready output.
- Used by the test-program loader to fill instruction memory.

---
 rtl/rv32i_encoder.sv | 136 +++++++++++++
 tb/tb_rv32i_encoder.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_encoder.sv
// Streaming RV32I instruction encoder: packs field bundles into 32-bit words
// with a running byte address, rejecting out-of-range immediates.
module rv32i_encoder #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 clear,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [2:0]           in_fmt,
   input  logic [6:0]           in_opcode,
   input  logic [4:0]           in_rd,
   input  logic [4:0]           in_rs1,
   input  logic [4:0]           in_rs2,
   input  logic [2:0]           in_funct3,
   input  logic [6:0]           in_funct7,
   input  logic [31:0]          in_imm,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [31:0]          out_instr,
   output logic [31:0]          out_addr,
   output logic                 err,
   output logic [ERR_CNT_W-1:0] err_count
);

   typedef enum logic [2:0] {
      FMT_R = 3'd0,
      FMT_I = 3'd1,
      FMT_S = 3'd2,
      FMT_B = 3'd3,
      FMT_U = 3'd4,
      FMT_J = 3'd5
   } fmt_e;

   logic                 valid_q, valid_d;
   logic [31:0]          instr_q, instr_d;
   logic [31:0]          addr_q, addr_d;
   logic [31:0]          pc_q, pc_d;
   logic                 err_q, err_d;
   logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

   logic        accept;
   logic        legal;
   logic [31:0] word;

   assign in_ready = !clear && (!valid_q || out_ready);
   assign accept   = in_valid && in_ready;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      word  = '0;
      legal = 1'b0;
      case (fmt_e'(in_fmt))
         FMT_R: begin
            word  = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            legal = 1'b1;
         end
         FMT_I: begin
            word  = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            legal = (&in_imm[31:11]) || !(|in_imm[31:11]);
         end
         FMT_S: begin
            word  = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
            legal = (&in_imm[31:11]) || !(|in_imm[31:11]);
         end
         FMT_B: begin
            word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                     in_imm[4:1], in_imm[11], in_opcode};
            legal = !in_imm[0] && ((&in_imm[31:12]) || !(|in_imm[31:12]));
         end
         FMT_U: begin
            word  = {in_imm[31:12], in_rd, in_opcode};
            legal = !(|in_imm[11:0]);
         end
         FMT_J: begin
            word  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
            legal = !in_imm[0] && ((&in_imm[31:20]) || !(|in_imm[31:20]));
         end
         default: ;
      endcase
   end

   // A transfer empties the register unless a legal bundle reloads it in the same cycle.
   always_comb begin
      valid_d   = valid_q && !out_ready;
      instr_d   = instr_q;
      addr_d    = addr_q;
      pc_d      = pc_q;
      err_d     = 1'b0;
      err_cnt_d = err_cnt_q;
      if (clear) begin
         valid_d   = 1'b0;
         pc_d      = BASE_ADDR;
         err_cnt_d = '0;
      end else if (accept) begin
         if (legal) begin
            valid_d = 1'b1;
            instr_d = word;
            addr_d  = pc_q;
            pc_d    = pc_q + 32'd4;
         end else begin
            err_d = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments and the async reset
   // sits in the sensitivity list so it acts without waiting for a clock edge.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         valid_q   <= 1'b0;
         instr_q   <= '0;
         addr_q    <= BASE_ADDR;
         pc_q      <= BASE_ADDR;
         err_q     <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         valid_q   <= valid_d;
         instr_q   <= instr_d;
         addr_q    <= addr_d;
         pc_q      <= pc_d;
         err_q     <= err_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign out_valid = valid_q;
   assign out_instr = instr_q;
   assign out_addr  = addr_q;
   assign err       = err_q;
   assign err_count = err_cnt_q;

endmodule

// File: tb/tb_rv32i_encoder.sv
// Scoreboard bench for rv32i_encoder: directed cases plus randomized bundles
// checked against a range/bit-position model of the RV32I formats.
module tb_rv32i_encoder;

   localparam logic [31:0] BASE    = 32'h0000_0000;
   localparam int          ERR_MAX = 255;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        clear = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  in_fmt = '0;
   logic [6:0]  in_opcode = '0;
   logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
   logic [2:0]  in_funct3 = '0;
   logic [6:0]  in_funct7 = '0;
   logic [31:0] in_imm = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_instr, out_addr;
   logic        err;
   logic [7:0]  err_count;

   rv32i_encoder #(.BASE_ADDR(BASE), .ERR_CNT_W(8)) dut (
      .clk(clk), .resetn(resetn), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
      .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_addr(out_addr),
      .err(err), .err_count(err_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] addr;
   } exp_t;

   exp_t exp_q[$];
   int   err_q[$];
   int   n_checks = 0;
   int   n_fail = 0;
   logic [31:0] mdl_addr = BASE;
   int   mdl_err = 0;
   logic rand_ready = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Legality as signed ranges and alignment of the immediate value.
   function automatic logic mdl_legal(input logic [2:0] fmt, input logic [31:0] imm);
      int s;
      s = $signed(imm);
      case (fmt)
         3'd0:       return 1'b1;
         3'd1, 3'd2: return (s >= -2048) && (s <= 2047);
         3'd3:       return (s % 2 == 0) && (s >= -4096) && (s <= 4095);
         3'd4:       return (imm % 4096) == 0;
         3'd5:       return (s % 2 == 0) && (s >= -(1 << 20)) && (s < (1 << 20));
         default:    return 1'b0;
      endcase
   endfunction

   // Field placement by shift-and-mask of each immediate slice.
   function automatic logic [31:0] mdl_enc(input logic [2:0] fmt, input logic [6:0] op,
                                           input logic [4:0] rd, rs1, rs2,
                                           input logic [2:0] f3, input logic [6:0] f7,
                                           input logic [31:0] imm);
      logic [31:0] u, base_rs, w;
      u       = imm;
      base_rs = (32'(rs1) << 15) | (32'(f3) << 12) | 32'(op);
      case (fmt)
         3'd0: w = (32'(f7) << 25) | (32'(rs2) << 20) | base_rs | (32'(rd) << 7);
         3'd1: w = ((u & 32'hFFF) << 20) | base_rs | (32'(rd) << 7);
         3'd2: w = (((u >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | base_rs | ((u & 32'h1F) << 7);
         3'd3: w = (((u >> 12) & 32'h1) << 31) | (((u >> 5) & 32'h3F) << 25) | (32'(rs2) << 20)
                   | base_rs | (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 32'h1) << 7);
         3'd4: w = (u & 32'hFFFF_F000) | (32'(rd) << 7) | 32'(op);
         default: w = (((u >> 20) & 32'h1) << 31) | (((u >> 1) & 32'h3FF) << 21)
                      | (((u >> 11) & 32'h1) << 20) | (((u >> 12) & 32'hFF) << 12)
                      | (32'(rd) << 7) | 32'(op);
      endcase
      return w;
   endfunction

   // Called and returns at posedge+1; the bundle is accepted at a rising edge.
   task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] imm,
                       input logic use_exp, input logic [31:0] exp_word);
      int   tries;
      exp_t e;
      in_valid = 1'b1; in_fmt = fmt; in_opcode = op; in_rd = rd; in_rs1 = rs1;
      in_rs2 = rs2; in_funct3 = f3; in_funct7 = f7; in_imm = imm;
      if (rand_ready) out_ready = ($urandom % 4) != 0;
      tries = 0;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         tries++;
         if (tries > 1000) begin
            check("accept_timeout", 32'(in_ready), 32'd1);
            @(posedge clk); #1 in_valid = 1'b0;
            return;
         end
         @(posedge clk); #1;
         if (rand_ready) out_ready = ($urandom % 4) != 0;
      end
      @(posedge clk);
      if (mdl_legal(fmt, imm)) begin
         e.instr = use_exp ? exp_word : mdl_enc(fmt, op, rd, rs1, rs2, f3, f7, imm);
         e.addr  = mdl_addr;
         exp_q.push_back(e);
         mdl_addr = mdl_addr + 32'd4;
      end else begin
         if (mdl_err < ERR_MAX) mdl_err++;
         err_q.push_back(mdl_err);
      end
      #1 in_valid = 1'b0;
      if (rand_ready) out_ready = ($urandom % 4) != 0;
   endtask

   task automatic idle();
      @(posedge clk); #1;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      in_valid = 1'b1; in_fmt = 3'd1; in_imm = 32'd1;
      @(negedge clk);
      check("in_ready_during_clear", 32'(in_ready), 32'd0);
      @(posedge clk);
      exp_q.delete();
      mdl_addr = BASE;
      mdl_err  = 0;
      #1 clear = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      check("clear_out_valid", 32'(out_valid), 32'd0);
      check("clear_err", 32'(err), 32'd0);
      check("clear_err_count", 32'(err_count), 32'd0);
      @(posedge clk); #1;
   endtask

   // Monitor: pops expected words on transfers and expected counts on err pulses.
   initial begin
      logic        stall = 1'b0;
      logic [31:0] held_instr = '0, held_addr = '0;
      exp_t        e;
      int          ec;
      forever begin
         @(negedge clk);
         if (!resetn) begin
            stall = 1'b0;
            continue;
         end
         if (stall && out_valid) begin
            check("hold_instr", out_instr, held_instr);
            check("hold_addr", out_addr, held_addr);
         end
         stall = out_valid && !out_ready;
         held_instr = out_instr;
         held_addr  = out_addr;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL unexpected_word: got 0x%08h @0x%08h, expected none", out_instr, out_addr);
            end else begin
               e = exp_q.pop_front();
               check("out_instr", out_instr, e.instr);
               check("out_addr", out_addr, e.addr);
            end
         end
         if (err) begin
            if (err_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL unexpected_err: got err_count %0d, expected no err", err_count);
            end else begin
               ec = err_q.pop_front();
               check("err_count", 32'(err_count), 32'(ec));
            end
         end
      end
   end

   initial begin
      logic [2:0]  f;
      logic [31:0] imm;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_instr", out_instr, 32'd0);
      check("rst_out_addr", out_addr, BASE);
      check("rst_err", 32'(err), 32'd0);
      check("rst_err_count", 32'(err_count), 32'd0);
      @(posedge clk); #1 resetn = 1'b1;
      idle();

      // ADDI x1,x0,5
      send(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1, 32'h0050_0093);
      idle(); idle();
      do_clear();

      // LUI x2 then JAL x1,8 back to back
      send(3'd4, 7'b0110111, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 1'b1, 32'h1234_5137);
      send(3'd5, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 1'b1, 32'h0080_00EF);
      // BEQ x1,x2,-4 and SW x5,8(x2)
      send(3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC, 1'b1, 32'hFE20_8EE3);
      send(3'd2, 7'b0100011, 5'd0, 5'd2, 5'd5, 3'b010, 7'd0, 32'd8, 1'b1, 32'h0051_2423);
      idle(); idle();
      do_clear();

      // Rejected bundles
      send(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800, 1'b0, 32'd0);
      @(negedge clk);
      check("reject_err_pulse", 32'(err), 32'd1);
      check("reject_no_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      send(3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3, 1'b0, 32'd0);
      send(3'd7, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b0, 32'd0);
      idle();
      check("err_count_after_3", 32'(err_count), 32'd3);
      send(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1, 32'h0050_0093);
      idle(); idle();

      // Backpressure: hold for 5 cycles, then transfer and reload together
      out_ready = 1'b0;
      send(3'd0, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'b0100000, 32'd0, 1'b1, 32'h4020_81B3);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_in_ready", 32'(in_ready), 32'd0);
         check("bp_out_valid", 32'(out_valid), 32'd1);
      end
      @(posedge clk); #1 out_ready = 1'b1;
      send(3'd1, 7'b0010011, 5'd4, 5'd4, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 1'b1, 32'hFFF2_0213);
      @(negedge clk);
      check("reload_no_bubble", 32'(out_valid), 32'd1);
      @(posedge clk); #1;
      idle();
      do_clear();

      // Randomized bundles against the model
      rand_ready = 1'b1;
      for (int n = 0; n < 400; n++) begin
         f = 3'($urandom_range(0, 7));
         case (f)
            3'd1, 3'd2: imm = 32'($urandom_range(0, 4095)) - 32'd2048;
            3'd3:       imm = (32'($urandom_range(0, 8191)) - 32'd4096) & ~32'd1;
            3'd4:       imm = $urandom & 32'hFFFF_F000;
            3'd5:       imm = (32'($urandom_range(0, 2097151)) - 32'd1048576) & ~32'd1;
            default:    imm = $urandom;
         endcase
         if ($urandom % 4 == 0) imm = $urandom;
         if ($urandom % 8 == 0) imm = imm ^ 32'd1;
         send(f, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
              3'($urandom), 7'($urandom), imm, 1'b0, 32'd0);
         if ($urandom % 5 == 0) idle();
      end
      rand_ready = 1'b0;
      out_ready  = 1'b1;
      repeat (3) idle();
      do_clear();

      // Saturation of the error counter
      for (int n = 0; n < 300; n++)
         send(3'd6, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b0, 32'd0);
      idle();
      check("err_count_saturated", 32'(err_count), 32'd255);

      // Clear drops a pending word and restarts addressing
      out_ready = 1'b0;
      send(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1, 32'h0050_0093);
      do_clear();
      out_ready = 1'b1;
      send(3'd4, 7'b0110111, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 1'b1, 32'h1234_5137);
      @(negedge clk);
      check("post_clear_addr", out_addr, BASE);
      @(posedge clk); #1;

      // Asynchronous reset while a word is pending
      out_ready = 1'b0;
      send(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7, 1'b1, 32'h0070_0093);
      @(negedge clk);
      check("pre_reset_valid", 32'(out_valid), 32'd1);
      #2 resetn = 1'b0;
      #1 check("async_reset_valid", 32'(out_valid), 32'd0);
      check("async_reset_addr", out_addr, BASE);
      exp_q.delete();
      err_q.delete();
      mdl_addr = BASE;
      mdl_err  = 0;
      @(posedge clk); #1 resetn = 1'b1;
      out_ready = 1'b1;
      send(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1, 32'h0050_0093);
      repeat (3) idle();

      check("exp_q_drained", 32'(exp_q.size()), 32'd0);
      check("err_q_drained", 32'(err_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
